// File: rtl/seg_display_ctrl_pkg.sv
// Shared definitions for the seven-segment display controller: FSM states,
// segment glyphs, the MemOrIO base address and the double-dabble adjust step.
package seg_display_ctrl_pkg;

  typedef enum logic [1:0] {
    SEG_IDLE = 2'd0,
    SEG_CONV = 2'd1,
    SEG_DONE = 2'd2
  } seg_state_t;

  localparam logic [31:0] SEG_BASE_ADDR = 32'hFFFF_FC00;
  localparam logic [31:0] OVERFLOW_WORD = 32'hEEEE_EEEE;

  // Glyphs are {dp,g,f,e,d,c,b,a}, active-high.
  localparam logic [7:0] GLYPH_0     = 8'h3F;
  localparam logic [7:0] GLYPH_1     = 8'h06;
  localparam logic [7:0] GLYPH_2     = 8'h5B;
  localparam logic [7:0] GLYPH_3     = 8'h4F;
  localparam logic [7:0] GLYPH_4     = 8'h66;
  localparam logic [7:0] GLYPH_5     = 8'h6D;
  localparam logic [7:0] GLYPH_6     = 8'h7D;
  localparam logic [7:0] GLYPH_7     = 8'h07;
  localparam logic [7:0] GLYPH_8     = 8'h7F;
  localparam logic [7:0] GLYPH_9     = 8'h6F;
  localparam logic [7:0] GLYPH_A     = 8'h77;
  localparam logic [7:0] GLYPH_B     = 8'h7C;
  localparam logic [7:0] GLYPH_C     = 8'h39;
  localparam logic [7:0] GLYPH_D     = 8'h5E;
  localparam logic [7:0] GLYPH_E     = 8'h79;
  localparam logic [7:0] GLYPH_F     = 8'h71;
  localparam logic [7:0] GLYPH_BLANK = 8'h00;

  // A nibble is at most 9 here, so the +3 never carries out of its 4 bits.
  function automatic logic [39:0] bcd_adjust(input logic [39:0] bcd);
    logic [39:0] res;
    res = bcd;
    for (int i = 0; i < 10; i++) begin
      if (bcd[4*i +: 4] >= 4'd5) res[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
    end
    return res;
  endfunction

endpackage

// File: rtl/seg_hex_decoder.sv
// Combinational 4-bit nibble to seven-segment pattern decoder (0-F).
module seg_hex_decoder
  import seg_display_ctrl_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [7:0] code
);

  always_comb begin
    code = GLYPH_BLANK;
    case (nibble)
      4'h0: code = GLYPH_0;
      4'h1: code = GLYPH_1;
      4'h2: code = GLYPH_2;
      4'h3: code = GLYPH_3;
      4'h4: code = GLYPH_4;
      4'h5: code = GLYPH_5;
      4'h6: code = GLYPH_6;
      4'h7: code = GLYPH_7;
      4'h8: code = GLYPH_8;
      4'h9: code = GLYPH_9;
      4'hA: code = GLYPH_A;
      4'hB: code = GLYPH_B;
      4'hC: code = GLYPH_C;
      4'hD: code = GLYPH_D;
      4'hE: code = GLYPH_E;
      4'hF: code = GLYPH_F;
      default: code = GLYPH_BLANK;
    endcase
  end

endmodule

// File: rtl/seg_display_ctrl.sv
// Seven-segment display controller: latches store data, optionally converts it
// to decimal by serial double-dabble, and scans 8 digits onto the board pins.
module seg_display_ctrl
  import seg_display_ctrl_pkg::*;
#(
  parameter int SCAN_DIV  = 100000,
  parameter int CONV_BITS = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        seg_we,
  input  logic [31:0] seg_wdata,
  input  logic        dec_mode,
  output logic        busy,
  output logic [7:0]  seg_an,
  output logic [7:0]  seg_code
);

  localparam int CNT_W = $clog2(SCAN_DIV);
  localparam int BIT_W = $clog2(CONV_BITS + 1);

  seg_state_t           state, state_next;
  logic [31:0]          disp_reg;
  logic [7:0]           blank_mask;
  logic [7:0]           blank_calc;
  logic [39:0]          bcd_reg;
  logic [39:0]          bcd_adj;
  logic [CONV_BITS-1:0] shift_reg;
  logic [BIT_W-1:0]     bit_cnt;
  logic [CNT_W-1:0]     scan_cnt;
  logic [2:0]           idx;
  logic [3:0]           nibble;
  logic [7:0]           glyph;
  logic                 overflow;
  logic                 higher_zero;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= SEG_IDLE;
    else     state <= state_next;
  end

  // Any write overrides the conversion in flight, so the aborted result never commits.
  always_comb begin
    state_next = state;
    busy       = (state != SEG_IDLE);
    case (state)
      SEG_CONV: if (bit_cnt == BIT_W'(CONV_BITS - 1)) state_next = SEG_DONE;
      SEG_DONE: state_next = SEG_IDLE;
      default:  state_next = SEG_IDLE;
    endcase
    if (seg_we) state_next = dec_mode ? SEG_CONV : SEG_IDLE;
  end

  assign bcd_adj  = bcd_adjust(bcd_reg);
  assign overflow = (bcd_reg[39:32] != 8'd0);

  always_comb begin
    blank_calc  = 8'd0;
    higher_zero = 1'b1;
    for (int i = 7; i >= 1; i--) begin
      higher_zero   = higher_zero & (bcd_reg[4*i +: 4] == 4'd0);
      blank_calc[i] = higher_zero;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      disp_reg   <= 32'd0;
      blank_mask <= 8'd0;
      bcd_reg    <= 40'd0;
      shift_reg  <= '0;
      bit_cnt    <= '0;
    end else if (seg_we) begin
      if (dec_mode) begin
        shift_reg <= seg_wdata[CONV_BITS-1:0];
        bcd_reg   <= 40'd0;
        bit_cnt   <= '0;
      end else begin
        disp_reg   <= seg_wdata;
        blank_mask <= 8'd0;
      end
    end else begin
      case (state)
        SEG_CONV: begin
          bcd_reg   <= {bcd_adj[38:0], shift_reg[CONV_BITS-1]};
          shift_reg <= shift_reg << 1;
          bit_cnt   <= bit_cnt + 1'b1;
        end
        SEG_DONE: begin
          disp_reg   <= overflow ? OVERFLOW_WORD : bcd_reg[31:0];
          blank_mask <= overflow ? 8'd0 : blank_calc;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scan_cnt <= '0;
      idx      <= 3'd0;
    end else if (scan_cnt == CNT_W'(SCAN_DIV - 1)) begin
      scan_cnt <= '0;
      idx      <= idx + 3'd1;
    end else begin
      scan_cnt <= scan_cnt + 1'b1;
    end
  end

  assign nibble = disp_reg[4*idx +: 4];

  seg_hex_decoder u_decoder (
    .nibble (nibble),
    .code   (glyph)
  );

  // Anode and cathode are registered together so a digit never shows its neighbour's code.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seg_an   <= 8'd0;
      seg_code <= 8'd0;
    end else begin
      seg_an   <= blank_mask[idx] ? 8'd0 : (8'd1 << idx);
      seg_code <= glyph;
    end
  end

endmodule

// File: tb/tb_seg_display_ctrl.sv
// Directed self-checking bench for seg_display_ctrl with a fast scan (SCAN_DIV=4).
module tb_seg_display_ctrl;

  localparam logic [63:0] G_ZEROS = {8{8'h3F}};
  localparam logic [63:0] G_HEX   = 64'h06_5B_4F_66_77_7C_39_5E;
  localparam logic [63:0] G_12345 = 64'h3F_3F_3F_06_5B_4F_66_6D;
  localparam logic [63:0] G_ERR   = {8{8'h79}};
  localparam logic [63:0] G_FFFF  = {8{8'h71}};

  logic        clk = 1'b0;
  logic        rst;
  logic        seg_we;
  logic [31:0] seg_wdata;
  logic        dec_mode;
  logic        busy;
  logic [7:0]  seg_an;
  logic [7:0]  seg_code;

  int tests_run = 0;
  int tests_failed = 0;

  seg_display_ctrl #(.SCAN_DIV(4), .CONV_BITS(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .seg_we    (seg_we),
    .seg_wdata (seg_wdata),
    .dec_mode  (dec_mode),
    .busy      (busy),
    .seg_an    (seg_an),
    .seg_code  (seg_code)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    tests_run++;
    assert (observed === expected) else begin
      tests_failed++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // One-cycle write strobe; returns at the falling edge after the capturing edge.
  task automatic applyStimulus(input logic [31:0] word, input logic dec);
    @(negedge clk);
    seg_we    = 1'b1;
    seg_wdata = word;
    dec_mode  = dec;
    @(negedge clk);
    seg_we    = 1'b0;
    dec_mode  = 1'b0;
  endtask

  task automatic waitConversion(input string tag);
    int n = 0;
    while (busy && n < 100) begin
      n++;
      @(negedge clk);
    end
    checkOutput({tag, "_busy_len"}, n, 33);
  endtask

  // Watches 40 cycles (more than one full scan) and checks every lit digit.
  task automatic checkScan(input string tag, input logic [63:0] glyphs, input logic [7:0] mask);
    logic [7:0] seen = 8'd0;
    logic [7:0] prev = 8'd0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      checkOutput({tag, "_busy"}, {31'd0, busy}, 32'd0);
      checkOutput({tag, "_an_mask"}, {24'd0, seg_an & ~mask}, 32'd0);
      if (mask == 8'hFF) checkOutput({tag, "_nogap"}, {31'd0, seg_an != 8'd0}, 32'd1);
      if (seg_an != 8'd0) begin
        checkOutput({tag, "_onehot"}, {31'd0, $onehot(seg_an)}, 32'd1);
        for (int d = 0; d < 8; d++) begin
          if (seg_an == (8'd1 << d)) begin
            checkOutput({tag, "_code"}, {24'd0, seg_code}, {24'd0, glyphs[8*d +: 8]});
            seen = seen | seg_an;
          end
        end
        if (prev != 8'd0 && seg_an != prev)
          checkOutput({tag, "_walk"}, {24'd0, seg_an}, {24'd0, prev[6:0], prev[7]});
      end
      prev = seg_an;
    end
    checkOutput({tag, "_seen"}, {24'd0, seen}, {24'd0, mask});
  endtask

  initial begin
    rst       = 1'b1;
    seg_we    = 1'b0;
    seg_wdata = 32'd0;
    dec_mode  = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("reset_an", {24'd0, seg_an}, 32'd0);
    checkOutput("reset_code", {24'd0, seg_code}, 32'd0);
    checkOutput("reset_busy", {31'd0, busy}, 32'd0);
    rst = 1'b0;
    checkScan("post_reset", G_ZEROS, 8'hFF);

    // Load something, then reset mid-scan while a write is attempted.
    applyStimulus(32'h8765_4321, 1'b0);
    repeat (5) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    checkOutput("midreset_an", {24'd0, seg_an}, 32'd0);
    checkOutput("midreset_code", {24'd0, seg_code}, 32'd0);
    @(negedge clk);
    seg_we    = 1'b1;
    seg_wdata = 32'h1234_5678;
    @(negedge clk);
    seg_we = 1'b0;
    @(negedge clk);
    checkOutput("midreset_hold_an", {24'd0, seg_an}, 32'd0);
    rst = 1'b0;
    checkScan("midreset_zeros", G_ZEROS, 8'hFF);

    applyStimulus(32'h1234_ABCD, 1'b0);
    checkOutput("hex_busy", {31'd0, busy}, 32'd0);
    checkScan("hex", G_HEX, 8'hFF);

    applyStimulus(32'd12345, 1'b1);
    checkOutput("dec_busy_start", {31'd0, busy}, 32'd1);
    waitConversion("dec12345");
    checkScan("dec12345", G_12345, 8'h1F);

    applyStimulus(32'd100_000_000, 1'b1);
    waitConversion("dec1e8");
    checkScan("dec1e8", G_ERR, 8'hFF);

    applyStimulus(32'd0, 1'b1);
    waitConversion("dec0");
    checkScan("dec0", G_ZEROS, 8'h01);

    applyStimulus(32'd999, 1'b1);
    checkOutput("abort_busy_start", {31'd0, busy}, 32'd1);
    repeat (9) @(negedge clk);
    applyStimulus(32'hFFFF_FFFF, 1'b0);
    checkOutput("abort_busy_drop", {31'd0, busy}, 32'd0);
    checkScan("abort_hex", G_FFFF, 8'hFF);

    applyStimulus(32'hFFFF_FFFF, 1'b1);
    waitConversion("decmax");
    checkScan("decmax", G_ERR, 8'hFF);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
